// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch/immediate/memory scheduling and datapath strobes.
// Optional single-step control is compiled in with SEQ_STEP_EN.
module cpu_sequencer (
  input  logic       clk,
  input  logic       rst,
`ifdef SEQ_STEP_EN
  input  logic       step_mode,
  input  logic       step,
`endif
  input  logic       run,
  input  logic       mem_ready,
  input  logic [7:0] mem_rdata,
  output logic       mem_req,
  output logic       mem_rw,
  output logic       mem_addr_sel,
  output logic       pc_inc,
  output logic       imm_load,
  output logic       alu_enable,
  output logic [2:0] alu_mode,
  output logic       direct_imm,
  output logic       reg_enable,
  output logic       reg_rw,
  output logic [1:0] rd_sel,
  output logic [1:0] rs_sel,
  output logic       wb_sel,
  output logic       flag_load,
  output logic       busy,
  output logic       instr_done
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_CMP  = 3'b101;
  localparam logic [2:0] ALU_PASS = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_IMM    = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6
  } state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] ir;
  logic [OP_W-1:0]   opcode;
  logic              is_imm, is_ld, is_st, is_cmp;
  logic [2:0]        op_mode;
  logic              start_ok, cont;

  // State and instruction register; IR loads only when the opcode byte arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && mem_ready) ir <= mem_rdata;
    end
  end

  assign opcode = ir[7:4];

  // Opcode class and ALU mode decode
  always_comb begin
    is_imm  = 1'b0;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    is_cmp  = 1'b0;
    op_mode = ALU_ADD;
    case (opcode)
      4'b0000: is_ld = 1'b1;
      4'b0001: is_st = 1'b1;
      4'b0011: op_mode = ALU_PASS;
      4'b0010: begin op_mode = ALU_PASS; is_imm = 1'b1; end
      4'b0100: op_mode = ALU_ADD;
      4'b1100: begin op_mode = ALU_ADD;  is_imm = 1'b1; end
      4'b0101: op_mode = ALU_SUB;
      4'b1101: begin op_mode = ALU_SUB;  is_imm = 1'b1; end
      4'b0110: op_mode = ALU_AND;
      4'b1110: begin op_mode = ALU_AND;  is_imm = 1'b1; end
      4'b1000: op_mode = ALU_OR;
      4'b1001: begin op_mode = ALU_OR;   is_imm = 1'b1; end
      4'b1010: op_mode = ALU_XOR;
      4'b1011: begin op_mode = ALU_XOR;  is_imm = 1'b1; end
      4'b0111: begin op_mode = ALU_CMP;  is_cmp = 1'b1; end
      4'b1111: begin op_mode = ALU_CMP;  is_cmp = 1'b1; is_imm = 1'b1; end
      default: op_mode = ALU_ADD;
    endcase
  end

  // Start/continue policy; single-step forces a return to IDLE after each instruction
`ifdef SEQ_STEP_EN
  assign start_ok = step_mode ? step : run;
  assign cont     = step_mode ? 1'b0 : run;
`else
  assign start_ok = run;
  assign cont     = run;
`endif

  // Next-state and strobe decode from registered state and IR
  always_comb begin
    state_nx     = state;
    mem_req      = 1'b0;
    mem_rw       = 1'b0;
    mem_addr_sel = 1'b0;
    pc_inc       = 1'b0;
    imm_load     = 1'b0;
    alu_enable   = 1'b0;
    alu_mode     = ALU_ADD;
    direct_imm   = 1'b0;
    reg_enable   = 1'b0;
    reg_rw       = 1'b0;
    wb_sel       = 1'b0;
    flag_load    = 1'b0;
    instr_done   = 1'b0;
    rd_sel       = ir[3:2];
    rs_sel       = ir[1:0];
    busy         = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start_ok) state_nx = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          pc_inc   = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_imm)              state_nx = S_IMM;
        else if (is_ld || is_st) state_nx = S_MEM;
        else                     state_nx = S_EXEC;
      end
      S_IMM: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          imm_load = 1'b1;
          pc_inc   = 1'b1;
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_enable = 1'b1;
        alu_mode   = op_mode;
        direct_imm = ~is_imm;
        flag_load  = 1'b1;
        if (is_cmp) begin
          instr_done = 1'b1;
          state_nx   = cont ? S_FETCH : S_IDLE;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_rw       = is_st;
        reg_enable   = is_st;
        if (mem_ready) begin
          if (is_st) begin
            instr_done = 1'b1;
            state_nx   = cont ? S_FETCH : S_IDLE;
          end else begin
            state_nx = S_WB;
          end
        end
      end
      S_WB: begin
        reg_enable = 1'b1;
        reg_rw     = 1'b1;
        wb_sel     = is_ld;
        instr_done = 1'b1;
        state_nx   = cont ? S_FETCH : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed cycle-by-cycle bench for cpu_sequencer; covers SEQ_STEP_EN when defined.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, mem_ready;
  logic [7:0] mem_rdata;
`ifdef SEQ_STEP_EN
  logic       step_mode, step;
`endif
  logic       mem_req, mem_rw, mem_addr_sel, pc_inc, imm_load, alu_enable;
  logic [2:0] alu_mode;
  logic       direct_imm, reg_enable, reg_rw, wb_sel, flag_load, busy, instr_done;
  logic [1:0] rd_sel, rs_sel;
  logic [19:0] outv;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .rst(rst),
`ifdef SEQ_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .run(run), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr_sel(mem_addr_sel),
    .pc_inc(pc_inc), .imm_load(imm_load), .alu_enable(alu_enable),
    .alu_mode(alu_mode), .direct_imm(direct_imm), .reg_enable(reg_enable),
    .reg_rw(reg_rw), .rd_sel(rd_sel), .rs_sel(rs_sel), .wb_sel(wb_sel),
    .flag_load(flag_load), .busy(busy), .instr_done(instr_done)
  );

  assign outv = {mem_req, mem_rw, mem_addr_sel, pc_inc, imm_load, alu_enable,
                 alu_mode, direct_imm, reg_enable, reg_rw, rd_sel, rs_sel,
                 wb_sel, flag_load, busy, instr_done};

  localparam logic [19:0] NONE = 20'h00000;
  localparam logic [19:0] REQ  = 20'h80000;
  localparam logic [19:0] RW   = 20'h40000;
  localparam logic [19:0] ASEL = 20'h20000;
  localparam logic [19:0] PCI  = 20'h10000;
  localparam logic [19:0] IML  = 20'h08000;
  localparam logic [19:0] ALUE = 20'h04000;
  localparam logic [19:0] DIMM = 20'h00400;
  localparam logic [19:0] REN  = 20'h00200;
  localparam logic [19:0] RRW  = 20'h00100;
  localparam logic [19:0] WBS  = 20'h00008;
  localparam logic [19:0] FL   = 20'h00004;
  localparam logic [19:0] BSY  = 20'h00002;
  localparam logic [19:0] DONE = 20'h00001;

  function automatic logic [19:0] md(input logic [2:0] m);
    return {6'b0, m, 11'b0};
  endfunction

  function automatic logic [19:0] rr(input logic [1:0] d, input logic [1:0] s);
    return {12'b0, d, s, 4'b0};
  endfunction

  // Apply inputs for the current cycle, compare all outputs, advance one clock
  task automatic cyc(input string tag, input logic rdy, input logic [7:0] rdata,
                     input logic [19:0] exp_v);
    mem_ready = rdy;
    mem_rdata = rdata;
    #1;
    vectors++;
    assert (outv === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %05h expected %05h", tag, outv, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; mem_rdata = 8'h00;
`ifdef SEQ_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc("reset", 1'b0, 8'h00, NONE);
    rst = 1'b0;
    cyc("idle_run0", 1'b0, 8'h00, NONE);

    // SUM r1,r2 zero-wait: 4 cycles
    run = 1'b1;
    cyc("sum_idle", 1'b0, 8'h00, NONE);
    cyc("sum_fetch", 1'b1, 8'h46, REQ | PCI | BSY);
    cyc("sum_decode", 1'b0, 8'h00, rr(2'd1, 2'd2) | BSY);
    cyc("sum_exec", 1'b0, 8'h00, ALUE | md(3'b000) | DIMM | rr(2'd1, 2'd2) | FL | BSY);
    cyc("sum_wb", 1'b0, 8'h00, REN | RRW | rr(2'd1, 2'd2) | BSY | DONE);

    // SMI 0xC4 + imm 0x07, two waits per access: 9 cycles, back to back
    cyc("smi_fetch_w1", 1'b0, 8'h00, REQ | rr(2'd1, 2'd2) | BSY);
    cyc("smi_fetch_w2", 1'b0, 8'h00, REQ | rr(2'd1, 2'd2) | BSY);
    cyc("smi_fetch", 1'b1, 8'hC4, REQ | PCI | rr(2'd1, 2'd2) | BSY);
    cyc("smi_decode", 1'b0, 8'h00, rr(2'd1, 2'd0) | BSY);
    cyc("smi_imm_w1", 1'b0, 8'h00, REQ | rr(2'd1, 2'd0) | BSY);
    cyc("smi_imm_w2", 1'b0, 8'h00, REQ | rr(2'd1, 2'd0) | BSY);
    cyc("smi_imm", 1'b1, 8'h07, REQ | PCI | IML | rr(2'd1, 2'd0) | BSY);
    cyc("smi_exec", 1'b0, 8'h00, ALUE | md(3'b000) | rr(2'd1, 2'd0) | FL | BSY);
    cyc("smi_wb", 1'b0, 8'h00, REN | RRW | rr(2'd1, 2'd0) | BSY | DONE);

    // LD r2,[r3]
    cyc("ld_fetch", 1'b1, 8'h0B, REQ | PCI | rr(2'd1, 2'd0) | BSY);
    cyc("ld_decode", 1'b0, 8'h00, rr(2'd2, 2'd3) | BSY);
    cyc("ld_mem", 1'b1, 8'h5A, REQ | ASEL | rr(2'd2, 2'd3) | BSY);
    cyc("ld_wb", 1'b0, 8'h00, REN | RRW | WBS | rr(2'd2, 2'd3) | BSY | DONE);

    // ST r2,[r3] with one wait: done in MEM, no WB
    cyc("st_fetch", 1'b1, 8'h1B, REQ | PCI | rr(2'd2, 2'd3) | BSY);
    cyc("st_decode", 1'b0, 8'h00, rr(2'd2, 2'd3) | BSY);
    cyc("st_mem_w1", 1'b0, 8'h00, REQ | RW | ASEL | REN | rr(2'd2, 2'd3) | BSY);
    cyc("st_mem", 1'b1, 8'h00, REQ | RW | ASEL | REN | rr(2'd2, 2'd3) | BSY | DONE);

    // CMI 0xF0: flags only, run dropped in EXEC returns to IDLE
    cyc("cmi_fetch", 1'b1, 8'hF0, REQ | PCI | rr(2'd2, 2'd3) | BSY);
    cyc("cmi_decode", 1'b0, 8'h00, BSY);
    cyc("cmi_imm", 1'b1, 8'h33, REQ | PCI | IML | BSY);
    run = 1'b0;
    cyc("cmi_exec", 1'b0, 8'h00, ALUE | md(3'b101) | FL | BSY | DONE);
    cyc("cmi_idle", 1'b0, 8'h00, NONE);

    // MR r3,r0: PASS with register operand, run dropped in WB
    run = 1'b1;
    cyc("mr_idle", 1'b0, 8'h00, NONE);
    cyc("mr_fetch", 1'b1, 8'h3C, REQ | PCI | BSY);
    cyc("mr_decode", 1'b0, 8'h00, rr(2'd3, 2'd0) | BSY);
    cyc("mr_exec", 1'b0, 8'h00, ALUE | md(3'b110) | DIMM | rr(2'd3, 2'd0) | FL | BSY);
    run = 1'b0;
    cyc("mr_wb", 1'b0, 8'h00, REN | RRW | rr(2'd3, 2'd0) | BSY | DONE);
    cyc("mr_idle_after", 1'b0, 8'h00, rr(2'd3, 2'd0));

    // XRI 0xB5 abandoned by reset while IMM request is pending
    run = 1'b1;
    cyc("xri_idle", 1'b0, 8'h00, rr(2'd3, 2'd0));
    cyc("xri_fetch", 1'b1, 8'hB5, REQ | PCI | rr(2'd3, 2'd0) | BSY);
    cyc("xri_decode", 1'b0, 8'h00, rr(2'd1, 2'd1) | BSY);
    cyc("xri_imm_w1", 1'b0, 8'h00, REQ | rr(2'd1, 2'd1) | BSY);
    rst = 1'b1;
    cyc("xri_imm_rst", 1'b0, 8'h00, REQ | rr(2'd1, 2'd1) | BSY);
    cyc("xri_after_rst", 1'b0, 8'h00, NONE);
    rst = 1'b0; run = 1'b0;
    cyc("post_rst_idle", 1'b0, 8'h00, NONE);

`ifdef SEQ_STEP_EN
    // Single-step: run ignored, one instruction per step pulse
    step_mode = 1'b1; run = 1'b1;
    cyc("step_wait1", 1'b0, 8'h00, NONE);
    cyc("step_wait2", 1'b0, 8'h00, NONE);
    step = 1'b1;
    cyc("step_pulse", 1'b0, 8'h00, NONE);
    step = 1'b0;
    cyc("step_fetch", 1'b1, 8'h46, REQ | PCI | BSY);
    cyc("step_decode", 1'b0, 8'h00, rr(2'd1, 2'd2) | BSY);
    cyc("step_exec", 1'b0, 8'h00, ALUE | md(3'b000) | DIMM | rr(2'd1, 2'd2) | FL | BSY);
    cyc("step_wb", 1'b0, 8'h00, REN | RRW | rr(2'd1, 2'd2) | BSY | DONE);
    cyc("step_idle1", 1'b0, 8'h00, rr(2'd1, 2'd2));
    cyc("step_idle2", 1'b0, 8'h00, rr(2'd1, 2'd2));
    step_mode = 1'b0; run = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle instruction sequencer for the 8-bit processor. It fetches instructions, and the second immediate byte where one exists, over the single shared memory port. It decodes the 4-bit opcode and drives the ALU, register-file and memory strobes cycle by cycle. It sits between the memory interface and the datapath, owns the instruction register and the memory-port schedule, and replaces static per-opcode decoding with a state machine.

## Interface
- No parameters. Data and instruction width is fixed at 8 bits.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level; while high, the sequencer keeps starting new instructions
- mem_ready  in  1  memory has completed the current request this cycle
- mem_rdata  in  8  memory read data; valid when mem_ready=1
- mem_req  out  1  memory request; held high until mem_ready
- mem_rw  out  1  1=write, 0=read
- mem_addr_sel  out  1  0=PC, 1=register rs
- pc_inc  out  1  one-cycle PC increment pulse
- imm_load  out  1  one-cycle strobe: the datapath captures mem_rdata into its immediate register
- alu_enable  out  1  ALU operates this cycle; the datapath latches the result
- alu_mode  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 CMP, 110 PASS
- direct_imm  out  1  ALU operand B source: 1=register rs, 0=immediate
- reg_enable, reg_rw  out  1 each  register-file access; reg_rw=1 means write
- rd_sel, rs_sel  out  2 each  IR[3:2] and IR[1:0]
- wb_sel  out  1  writeback source: 0=ALU result, 1=mem_rdata
- flag_load  out  1  one-cycle strobe: the datapath captures ALU flags
- busy  out  1  high in every state except IDLE
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction

## Operation
- Opcode is IR[7:4]:
  - LD 0000: rd <= mem[rs]
  - ST 0001: mem[rs] <= rd
  - MR 0011, MI 0010: PASS
  - SUM 0100, SMI 1100: ADD
  - SB 0101, SBI 1101: SUB
  - ANR 0110, ANI 1110: AND
  - ORR 1000, ORI 1001: OR
  - XRR 1010, XRI 1011: XOR
  - CM 0111, CMI 1111: CMP, which updates flags only and does no writeback
- Immediate opcodes are MI, SMI, SBI, ANI, ORI, XRI and CMI. All 16 opcodes are legal.
- States: IDLE, FETCH, DECODE, IMM, EXEC, MEM, WB.
- IDLE → FETCH when run=1.
- FETCH:
  - Drive mem_req=1, mem_addr_sel=0, mem_rw=0.
  - On mem_ready: IR <= mem_rdata, pc_inc=1, go to DECODE.
- DECODE (one cycle, no strobes):
  - immediate opcode → IMM
  - LD/ST → MEM
  - otherwise → EXEC
- IMM:
  - Drive mem_req=1, mem_addr_sel=0.
  - On mem_ready: imm_load=1, pc_inc=1, go to EXEC.
- EXEC (one cycle):
  - Drive alu_enable=1, alu_mode per opcode, direct_imm = 0 for immediate opcodes and 1 otherwise.
  - CM/CMI: flag_load=1, instr_done=1, then go to next.
  - All other opcodes: flag_load=1, go to WB.
- MEM:
  - Drive mem_req=1, mem_addr_sel=1, mem_rw=1 for ST; for ST also drive reg_enable=1, reg_rw=0 to read rd.
  - On mem_ready, LD: latch data internally, go to WB with wb_sel=1.
  - On mem_ready, ST: instr_done=1, then go to next.
- WB (one cycle):
  - Drive reg_enable=1, reg_rw=1, wb_sel = 1 for LD and 0 otherwise.
  - Drive instr_done=1, then go to next.
- "Next" is FETCH if run=1, else IDLE.
- run is sampled only when starting an instruction. Dropping run mid-instruction completes the current instruction.
- rd_sel and rs_sel always reflect IR.
- All outputs are decoded from the registered state and IR only. No combinational path exists from mem_ready to any output except the strobes qualified by mem_ready in the same cycle: pc_inc, imm_load, instr_done.

## Timing
- Reset:
  - State = IDLE, IR = 8'h00.
  - Every output is 0. rd_sel, rs_sel and alu_mode are 0.
- rst has priority over every transition. Asserting rst mid-instruction abandons it and drops mem_req on the next cycle; the memory interface tolerates an abandoned request.
- Cycles from FETCH entry to instr_done with zero-wait memory (mem_ready high in the first request cycle):

  | Instruction class | Cycles |
  |---|---|
  | register ALU op | 4 |
  | immediate ALU op | 5 |
  | CM | 3 |
  | CMI | 4 |
  | LD | 4 |
  | ST | 3 |

- Each memory wait cycle adds one cycle.
- mem_req, mem_addr_sel and mem_rw stay stable while waiting for mem_ready.
- Back-to-back instructions: with run=1, FETCH is entered on the cycle after instr_done, with no idle bubble.

## Configuration
- SEQ_STEP_EN defined:
  - Adds inputs step_mode (1 bit) and step (1-bit pulse).
  - While step_mode=1, the IDLE → FETCH transition requires step=1, and "next" is always IDLE.
  - The result is exactly one instruction per step pulse. run is ignored while step_mode=1.
- SEQ_STEP_EN undefined:
  - The step_mode and step ports are absent.
  - Behaviour is identical to step_mode=0.

## Test plan
- Reset mid-IMM with mem_req high → next cycle all outputs 0, busy=0, state IDLE.
- run=1, zero-wait memory, instruction 8'h46 (SUM rd=1, rs=2) → FETCH, DECODE, EXEC (alu_mode=000, direct_imm=1), WB (reg_rw=1, rd_sel=1); instr_done in cycle 4; pc_inc once.
- Instruction 8'hC4 followed by immediate byte 8'h07, with 2 wait cycles on each access → imm_load when the second byte arrives, pc_inc twice, alu_mode=000, direct_imm=0; instr_done in cycle 9.
- LD 8'h0B, mem_rdata 8'h5A → MEM with mem_addr_sel=1, mem_rw=0; WB with wb_sel=1, rd_sel=2. ST 8'h1B → mem_rw=1; instr_done in MEM; no WB.
- CMI 8'hF0 → flag_load=1 in EXEC, no reg_rw; run dropped during EXEC → IDLE after instr_done.
- With SEQ_STEP_EN and step_mode=1, run=1 → no fetch until a step pulse; exactly one instruction per pulse, then IDLE.
